// File: rtl/ddr3_rdcal_ctrl.sv
// ddr3_rdcal_ctrl
//   Read-capture calibration controller for the DDR IOB/IDES4 layer. For each
//   candidate word-alignment shift (0..3) it applies the shift to every lane
//   that is still unlocked, lets the IOBs settle, and issues BURSTS pattern
//   reads. Each captured beat is compared against PAT_Q0/PAT_Q1 per lane. A lane
//   that sees no mismatch is locked at that shift. The sweep ends when every lane
//   is locked or when shift 3 has been tried.
//
// Ports
//   clock, reset_n        : bus clock (IOB PCLK domain), async active-low reset
//   start                 : one-cycle pulse; only honoured while idle
//   busy / done / fail    : status; done and fail stay set until the next start
//   lane_ok[LANES]        : per-lane lock flags
//   shift[2*LANES]        : per-lane SHIFT; lane i is shift[2i+1:2i]
//   rd_req / rd_ack       : pattern-read request handshake
//   rd_valid, rd_q0, rd_q1: captured beats, lane-packed 8 bits per lane
//   state_dbg             : current FSM state encoding, for observation only
//
// Handshake: rd_req stays high until a cycle in which rd_ack is high. That
// cycle is the transfer (it counts even if rd_ack was already high when rd_req
// rose), and rd_req is low from the next cycle on. rd_valid has no back-pressure.
// It is only looked at while a burst is being captured.
module ddr3_rdcal_ctrl #(
  parameter int          LANES   = 2,
  parameter int          BEATS   = 4,
  parameter int          BURSTS  = 4,
  parameter int          SETTLE  = 8,
  parameter int          TIMEOUT = 64,
  parameter logic [7:0]  PAT_Q0  = 8'h00,
  parameter logic [7:0]  PAT_Q1  = 8'hFF
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 fail,
  output logic [LANES-1:0]     lane_ok,
  output logic [2*LANES-1:0]   shift,
  output logic                 rd_req,
  input  logic                 rd_ack,
  input  logic                 rd_valid,
  input  logic [8*LANES-1:0]   rd_q0,
  input  logic [8*LANES-1:0]   rd_q1,
  output logic [2:0]           state_dbg
);

  localparam int SW = $clog2(SETTLE + 1);
  localparam int BW = $clog2(BEATS + 1);
  localparam int RW = $clog2(BURSTS + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SET  = 3'd1,
    S_REQ  = 3'd2,
    S_CAPT = 3'd3,
    S_EVAL = 3'd4,
    S_FIN  = 3'd5
  } state_t;

  state_t           state, state_nxt;
  logic [1:0]       cand;
  logic [SW-1:0]    settle_cnt;
  logic [BW-1:0]    beat_cnt;
  logic [RW-1:0]    burst_cnt;
  logic [TW-1:0]    to_cnt;
  logic [LANES-1:0] mism;
  logic [LANES-1:0] lane_bad;
  logic [LANES-1:0] new_lock;
  logic             settle_end;
  logic             last_beat;
  logic             last_burst;
  logic             to_hit;
  logic             all_locked;
  logic             sweep_end;

  always_comb begin
    lane_bad = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_bad[i] = (rd_q0[8*i +: 8] != PAT_Q0) || (rd_q1[8*i +: 8] != PAT_Q1);
    end
  end

  assign settle_end = (settle_cnt == SW'(SETTLE - 1));
  assign last_beat  = (beat_cnt == BW'(BEATS - 1));
  assign last_burst = (burst_cnt == RW'(BURSTS - 1));
  // The timeout only guards the wait for the first beat of a burst.
  assign to_hit     = (beat_cnt == '0) && (to_cnt == TW'(TIMEOUT - 1));
  assign new_lock   = ~lane_ok & ~mism;
  assign all_locked = &(lane_ok | new_lock);
  assign sweep_end  = all_locked || (cand == 2'd3);

  // Combinational so that an asynchronous reset drops the request immediately.
  assign rd_req    = (state == S_REQ);
  assign state_dbg = state;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_SET;
      S_SET:  if (settle_end) state_nxt = S_REQ;
      S_REQ:  if (rd_ack) state_nxt = S_CAPT;
      S_CAPT: begin
        if (rd_valid) begin
          if (last_beat) state_nxt = last_burst ? S_EVAL : S_REQ;
        end else if (to_hit) begin
          state_nxt = S_IDLE;
        end
      end
      S_EVAL: state_nxt = sweep_end ? S_FIN : S_SET;
      S_FIN:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      fail       <= 1'b0;
      lane_ok    <= '0;
      shift      <= '0;
      cand       <= '0;
      settle_cnt <= '0;
      beat_cnt   <= '0;
      burst_cnt  <= '0;
      to_cnt     <= '0;
      mism       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            done       <= 1'b0;
            fail       <= 1'b0;
            lane_ok    <= '0;
            shift      <= '0;
            cand       <= '0;
            settle_cnt <= '0;
            busy       <= 1'b1;
          end
        end
        S_SET: begin
          // Locked lanes keep the shift they were frozen at.
          for (int i = 0; i < LANES; i++) begin
            if (!lane_ok[i]) shift[2*i +: 2] <= cand;
          end
          if (settle_end) begin
            settle_cnt <= '0;
            mism       <= '0;
            burst_cnt  <= '0;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        S_REQ: begin
          if (rd_ack) begin
            beat_cnt <= '0;
            to_cnt   <= '0;
          end
        end
        S_CAPT: begin
          if (rd_valid) begin
            mism <= mism | lane_bad;
            if (last_beat) begin
              beat_cnt  <= '0;
              burst_cnt <= burst_cnt + 1'b1;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end else if (beat_cnt == '0) begin
            if (to_hit) begin
              fail <= 1'b1;
              done <= 1'b1;
              busy <= 1'b0;
            end else begin
              to_cnt <= to_cnt + 1'b1;
            end
          end
        end
        S_EVAL: begin
          // shift already holds cand for every unlocked lane, so locking only
          // needs the flag.
          lane_ok    <= lane_ok | new_lock;
          settle_cnt <= '0;
          if (!sweep_end) cand <= cand + 2'd1;
        end
        S_FIN: begin
          done <= 1'b1;
          fail <= ~&lane_ok;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
